// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

    localparam int DROP_CNT_W_DEF = 8;
    localparam logic [DROP_CNT_W_DEF-1:0] DROP_CNT_MAX = '1;

    // A select field is always at least one bit wide, even for tiny fan-outs.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side stream plus the NUM_OUT consumer-side streams of the demux.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int NUM_OUT    = 4,
    parameter int DROP_CNT_W = 8
);
    localparam int SEL_W = sel_width(NUM_OUT);

    logic                          in_valid;
    logic                          in_ready;
    logic [DATAWIDTH-1:0]          in_data;
    logic [SEL_W-1:0]              in_sel;
    logic [NUM_OUT-1:0]            out_valid;
    logic [NUM_OUT-1:0]            out_ready;
    logic [NUM_OUT*DATAWIDTH-1:0]  out_data;
    logic [DROP_CNT_W-1:0]         drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry holding register for a single demux output, with pass-through refill.
module demux_slot #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] load_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 can_load
);

    logic                 valid_q;
    logic [DATAWIDTH-1:0] data_q;

    // A draining slot can be refilled in the same cycle.
    assign can_load  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            // NOTE: the payload register is reset too, because out_data must read zero after reset.
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out_data));

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux: select decode, in_ready mux and drop counter around NUM_OUT slots.
module stream_demux_1ton
    import stream_demux_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int NUM_OUT    = 4,
    parameter int DROP_CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    stream_demux_if.slave bus
);

    localparam int SEL_W    = sel_width(NUM_OUT);
    localparam int SEL_SPAN = 1 << SEL_W;

    logic [NUM_OUT-1:0]           can_load;
    logic [NUM_OUT-1:0]           load;
    logic [NUM_OUT-1:0]           slot_valid;
    logic [NUM_OUT*DATAWIDTH-1:0] slot_data;
    logic [SEL_SPAN-1:0]          can_load_pad;
    logic                         in_range;
    logic                         accept;
    logic [DROP_CNT_W-1:0]        drop_cnt_q;

    // Unused select codes read as ready so out-of-range beats are always swallowed.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        can_load_pad              = '1;
        can_load_pad[NUM_OUT-1:0] = can_load;
    end

    assign in_range     = (int'(bus.in_sel) < NUM_OUT);
    assign bus.in_ready = can_load_pad[bus.in_sel];
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        assign load[i] = accept & (bus.in_sel == SEL_W'(i));

        demux_slot #(.DATAWIDTH(DATAWIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[i]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[i]),
            .out_valid (slot_valid[i]),
            .out_data  (slot_data[i*DATAWIDTH +: DATAWIDTH]),
            .can_load  (can_load[i])
        );
    end

    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (accept && !in_range && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;

    a_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.in_valid && !bus.in_ready |=> $stable(bus.in_sel) && $stable(bus.in_data));

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Self-checking bench for stream_demux_1ton: directed table, corner sequences, random scoreboard.
module tb_stream_demux_1ton;
    import stream_demux_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    stream_demux_if #(.DATAWIDTH(8), .NUM_OUT(4), .DROP_CNT_W(8)) bus4 ();
    stream_demux_if #(.DATAWIDTH(8), .NUM_OUT(3), .DROP_CNT_W(8)) bus3 ();

    stream_demux_1ton #(.DATAWIDTH(8), .NUM_OUT(4), .DROP_CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );
    stream_demux_1ton #(.DATAWIDTH(8), .NUM_OUT(3), .DROP_CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  rdy;
        logic        exp_in_ready;
        logic [3:0]  exp_out_valid;
        logic [31:0] exp_out_data;
    } vec_t;

    vec_t tbl [11];

    // Scoreboard: beats accepted but not yet handed over, per output port.
    logic [7:0] sb_q [4][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic [1:0] sel, input logic [7:0] data,
                          input logic [3:0] rdy);
        bus4.in_valid  = v;
        bus4.in_sel    = sel;
        bus4.in_data   = data;
        bus4.out_ready = rdy;
    endtask

    initial begin
        int accepted;
        int delivered;
        int pending;
        int cyc;
        logic stalled;
        logic [3:0] exp_valid;
        logic exp_rdy;
        logic [7:0] exp_byte;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        bus3.in_valid  = 1'b0;
        bus3.in_sel    = 2'd0;
        bus3.in_data   = 8'h00;
        bus3.out_ready = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state on both instances.
        #1;
        check("rst_out_valid4", bus4.out_valid, 4'b0000);
        check("rst_in_ready4", bus4.in_ready, 1'b1);
        check("rst_drop4", bus4.drop_cnt, 8'h00);
        check("rst_out_data4", bus4.out_data, 32'h0);
        check("rst_out_valid3", bus3.out_valid, 3'b000);
        check("rst_drop3", bus3.drop_cnt, 8'h00);
        @(negedge clk);

        // Directed table: stall, independent port, drain, drain+refill, no cross-port ready path.
        tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0000, 32'h0000_0000};
        tbl[1]  = '{1'b0, 2'd2, 8'h77, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000};
        tbl[2]  = '{1'b1, 2'd1, 8'h3C, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000};
        tbl[3]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0110, 32'h00A5_3C00};
        tbl[4]  = '{1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 4'b0110, 32'h00A5_3C00};
        tbl[5]  = '{1'b1, 2'd2, 8'h5E, 4'b0100, 1'b1, 4'b0010, 32'h00A5_3C00};
        tbl[6]  = '{1'b1, 2'd2, 8'h6B, 4'b0100, 1'b1, 4'b0110, 32'h005E_3C00};
        tbl[7]  = '{1'b0, 2'd1, 8'h00, 4'b0000, 1'b0, 4'b0110, 32'h006B_3C00};
        tbl[8]  = '{1'b0, 2'd1, 8'h00, 4'b0100, 1'b0, 4'b0110, 32'h006B_3C00};
        tbl[9]  = '{1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, 4'b0010, 32'h006B_3C00};
        tbl[10] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 32'h006B_3C00};
        for (int r = 0; r < 11; r++) begin
            drive4(tbl[r].v, tbl[r].sel, tbl[r].data, tbl[r].rdy);
            #1;
            check($sformatf("tbl%0d_in_ready", r), bus4.in_ready, tbl[r].exp_in_ready);
            check($sformatf("tbl%0d_out_valid", r), bus4.out_valid, tbl[r].exp_out_valid);
            check($sformatf("tbl%0d_out_data", r), bus4.out_data, tbl[r].exp_out_data);
            @(negedge clk);
        end

        // Full-throughput stream of 8 beats to port 0.
        for (int k = 0; k < 10; k++) begin
            drive4(k < 8, 2'd0, 8'(k), 4'b0001);
            #1;
            if (k < 8) check($sformatf("stream%0d_in_ready", k), bus4.in_ready, 1'b1);
            check($sformatf("stream%0d_valid", k), bus4.out_valid[0], (k >= 1 && k <= 8));
            if (k >= 1 && k <= 8)
                check($sformatf("stream%0d_data", k), bus4.out_data[7:0], 8'(k - 1));
            @(negedge clk);
        end
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);

        // Out-of-range select on the 3-port instance: every beat dropped, counter saturates.
        for (int k = 0; k < 300; k++) begin
            bus3.in_valid = 1'b1;
            bus3.in_sel   = 2'd3;
            bus3.in_data  = 8'hFF;
            #1;
            check("drop_in_ready", bus3.in_ready, 1'b1);
            check("drop_out_valid", bus3.out_valid, 3'b000);
            check($sformatf("drop_cnt_at_%0d", k), bus3.drop_cnt, (k > 255) ? 255 : k);
            @(negedge clk);
        end
        bus3.in_valid = 1'b0;
        #1;
        check("drop_cnt_sat", bus3.drop_cnt, DROP_CNT_MAX);
        @(negedge clk);

        // Fill slots 0 and 3, then a one-cycle reset pulse mid-stream.
        drive4(1'b1, 2'd0, 8'h11, 4'b0000);
        @(negedge clk);
        drive4(1'b1, 2'd3, 8'h22, 4'b0000);
        @(negedge clk);
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        check("prerst_out_valid", bus4.out_valid, 4'b1001);
        check("prerst_out_data", {bus4.out_data[31:24], bus4.out_data[7:0]}, 16'h2211);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus4.out_valid, 4'b0000);
        check("async_rst_drop3", bus3.drop_cnt, 8'h00);
        check("async_rst_out_data", bus4.out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive4(1'b1, 2'd3, 8'h5A, 4'b0000);
        #1;
        check("postrst_in_ready", bus4.in_ready, 1'b1);
        check("postrst_out_valid0", bus4.out_valid, 4'b0000);
        @(negedge clk);
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        check("postrst_out_valid1", bus4.out_valid, 4'b1000);
        check("postrst_out_data", bus4.out_data[31:24], 8'h5A);
        @(negedge clk);
        drive4(1'b0, 2'd0, 8'h00, 4'b1111);
        @(negedge clk);
        drive4(1'b0, 2'd0, 8'h00, 4'b0000);
        #1;
        check("drained_out_valid", bus4.out_valid, 4'b0000);
        @(negedge clk);

        // Random traffic against per-port FIFO scoreboard.
        accepted  = 0;
        delivered = 0;
        pending   = 0;
        cyc       = 0;
        stalled   = 1'b0;
        while ((accepted < 1000 || pending > 0) && cyc < 20000) begin
            bus4.out_ready = (accepted < 1000) ? 4'($urandom) : 4'b1111;
            if (!stalled) begin
                bus4.in_valid = (accepted < 1000) && ($urandom_range(3) != 0);
                bus4.in_sel   = 2'($urandom_range(3));
                bus4.in_data  = 8'($urandom);
            end
            #1;
            for (int i = 0; i < 4; i++) exp_valid[i] = (sb_q[i].size() != 0);
            exp_rdy = (sb_q[bus4.in_sel].size() == 0) || bus4.out_ready[bus4.in_sel];
            check("rand_out_valid", bus4.out_valid, exp_valid);
            check("rand_in_ready", bus4.in_ready, exp_rdy);
            for (int i = 0; i < 4; i++) begin
                if (exp_valid[i] && bus4.out_ready[i]) begin
                    exp_byte = sb_q[i].pop_front();
                    check($sformatf("rand_data_port%0d", i), bus4.out_data[i*8 +: 8], exp_byte);
                    delivered++;
                end
            end
            if (bus4.in_valid && exp_rdy) begin
                sb_q[bus4.in_sel].push_back(bus4.in_data);
                accepted++;
            end
            stalled = bus4.in_valid && !exp_rdy;
            pending = 0;
            for (int i = 0; i < 4; i++) pending += sb_q[i].size();
            cyc++;
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        check("rand_beats_accepted", accepted, 1000);
        check("rand_beats_delivered", delivered, accepted);
        check("rand_pending", pending, 0);
        check("rand_drop4", bus4.drop_cnt, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1ton

Overview:
- Registered 1-to-N stream demultiplexer: the distribution-side counterpart to the combinational mux trees.
- Accepts one valid/ready input stream tagged with a destination select, and routes each beat into a one-entry holding register per output.
- A stalled output does not block traffic to other outputs.
- Sits between a single producer and NUM_OUT independent consumers.

Parameters:
- DATAWIDTH, 8, payload width in bits.
- NUM_OUT, 4, number of output ports; legal range 2..16.
- SEL_W, $clog2(NUM_OUT), width of the select field; derived, never overridden.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat can be accepted this cycle.
- in_data  in  DATAWIDTH  input payload.
- in_sel  in  SEL_W  destination index, sampled with in_data.
- out_valid  out  NUM_OUT  per-output valid.
- out_ready  in  NUM_OUT  per-output ready.
- out_data  out  NUM_OUT*DATAWIDTH  packed payloads; output i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- drop_cnt  out  DROP_CNT_W  count of beats discarded for an out-of-range in_sel; saturating.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - out_valid = 0, out_data = 0, drop_cnt = 0.
  - in_ready = 1 after reset, because all slots are empty.
- Slot i:
  - State is slot_valid[i] and slot_data[i]; out_valid[i] = slot_valid[i] and out_data[i] = slot_data[i], both driven straight from registers.
  - Drain: when out_valid[i] & out_ready[i], the slot empties on the next edge unless it is refilled in the same cycle.
- in_ready (combinational from in_sel, slot_valid and out_ready; no path from in_valid):
  - For in_sel < NUM_OUT: in_ready = !slot_valid[in_sel] | out_ready[in_sel]. This is a pass-through refill, giving full throughput of 1 beat/cycle per output.
  - For in_sel >= NUM_OUT: in_ready = 1.
- Accept (in_valid & in_ready):
  - Legal sel: slot_valid[in_sel] <= 1 and slot_data[in_sel] <= in_data on the next edge.
  - Illegal sel: the beat is discarded and drop_cnt increments, saturating at all-ones. No output changes.
- Simultaneous drain and refill of the same slot: the slot stays valid and takes the new data, so out_valid is high on consecutive cycles.
- Latency: an accepted beat appears on out_valid/out_data on the cycle after acceptance (1 cycle).
- Ordering and stability:
  - Beats for a given output leave in acceptance order.
  - Beats to different outputs have no mutual ordering guarantee.
  - While out_valid[i] & !out_ready[i], out_data[i] holds stable.
- Mid-operation reset: all slots are cleared immediately and any held data is lost. drop_cnt clears.
- No state machine beyond per-slot full/empty. No combinational path from out_ready[j] to in_ready when in_sel != j.
- Assertions:
  - in_sel and in_data stable while in_valid & !in_ready (producer obligation; checked with an SVA).
  - out_valid never deasserts without a handshake.

Decomposition:
- Package stream_demux_pkg: function sel_width(n) returning $clog2(n) with a minimum of 1, and the localparam DROP_CNT_MAX.
- Sub-module demux_slot #(DATAWIDTH):
  - Inputs: clk, rst_n, load, load_data, out_ready.
  - Outputs: out_valid, out_data, can_load.
  - Instantiated NUM_OUT times in a generate loop.
- The top level holds the select decode, in_ready mux and drop counter.

Test Plan:
- Reset with NUM_OUT=4, all out_ready=0 -> out_valid=4'b0000, in_ready=1, drop_cnt=0.
- Send in_sel=2, data 8'hA5; hold out_ready[2]=0 -> out_valid=4'b0100 next cycle, out_data[2]=8'hA5 held. A second beat to sel=2 sees in_ready=0. A beat to sel=1 (8'h3C) is accepted, giving out_valid=4'b0110.
- Stream 8 beats 8'h00..8'h07 to sel=0 with out_ready[0]=1 throughout -> in_ready stays 1 and out_valid[0] is high for 8 consecutive cycles, starting 1 cycle after the first accept, with data in order.
- NUM_OUT=3, in_sel=3 with data 8'hFF for 300 beats -> in_ready=1, no out_valid, drop_cnt saturates at 8'hFF.
- Fill slots 0 and 3, then pulse rst_n low for 1 cycle mid-stream -> out_valid drops to 0 asynchronously and drop_cnt=0. After release, a beat to sel=3 (8'h5A) appears 1 cycle after acceptance.
- Randomised out_ready on all 4 ports, 1000 beats with random sel -> scoreboard shows every in-range beat delivered once, per-port order preserved, and no handshake-stability violations.
